// File: rtl/tftp_mode_decode.sv
// tftp_mode_decode: byte-serial matcher for the mode field of a TFTP RRQ/WRQ.
// Recognises "netascii", "octet" and (optionally) "mail", with optional
// ASCII case folding and a bounded field length. The result (done/valid/
// error/mode) is registered and held until the next start pulse.
//
// Build option: define TFTP_MODE_MAIL_EN to make "mail" a candidate
// (mode code 3). Without it the mail candidate is permanently disqualified.

module tftp_mode_decode #(
    parameter int unsigned MAX_LEN          = 8,
    parameter bit          CASE_INSENSITIVE = 1'b1,
    parameter int unsigned CNT_W            = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       en,
    input  logic [7:0] eth_data,
    output logic       done,
    output logic       valid,
    output logic       error,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Candidate strings, right-justified so char k of a length-L string
    // sits at bits [8*(L-1-k) +: 8].
    localparam logic [63:0] STR_NET   = "netascii";
    localparam logic [63:0] STR_OCTET = {24'h0, "octet"};
    localparam logic [63:0] STR_MAIL  = {32'h0, "mail"};

    localparam int unsigned LEN_NET   = 8;
    localparam int unsigned LEN_OCTET = 5;
    localparam int unsigned LEN_MAIL  = 4;

    // Flag bit order: [0] netascii, [1] octet, [2] mail.
`ifdef TFTP_MODE_MAIL_EN
    localparam logic [2:0] FLAG_INIT = 3'b111;
`else
    localparam logic [2:0] FLAG_INIT = 3'b011;
`endif

    localparam logic [CNT_W-1:0] IDX_LIMIT = CNT_W'(MAX_LEN);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] idx, idx_nxt;
    logic [2:0]       flags, flags_nxt;
    logic             done_nxt, valid_nxt, error_nxt;
    logic [1:0]       mode_nxt;

    // Effective view of the matcher this cycle: a start pulse behaves as if
    // the field had just been cleared, so a byte arriving with start is
    // processed as index 0 of the new field.
    logic             active;
    logic [CNT_W-1:0] cur_idx;
    logic [2:0]       cur_flags;
    logic [7:0]       byte_in;
    logic             is_nul;
    logic             overflow;
    logic [2:0]       char_hit;
    logic [2:0]       len_hit;
    logic [2:0]       hits;

    function automatic logic char_match(
        input logic [63:0] s,
        input int unsigned len,
        input int unsigned k,
        input logic [7:0]  b
    );
        logic r;
        r = 1'b0;
        if (k < len) begin
            r = (s[8*(len-1-k) +: 8] == b);
        end
        return r;
    endfunction

    // Byte conditioning and per-candidate compare against the current index
    always_comb begin
        int unsigned k;
        active    = start || (state == MATCH);
        cur_idx   = start ? '0 : idx;
        cur_flags = start ? FLAG_INIT : flags;
        k         = 32'(cur_idx);

        byte_in = eth_data;
        if (CASE_INSENSITIVE && (eth_data >= 8'h41) && (eth_data <= 8'h5A)) begin
            byte_in = eth_data | 8'h20;
        end

        is_nul   = (eth_data == 8'h00);
        overflow = !is_nul && (cur_idx == IDX_LIMIT);

        char_hit[0] = char_match(STR_NET,   LEN_NET,   k, byte_in);
        char_hit[1] = char_match(STR_OCTET, LEN_OCTET, k, byte_in);
        char_hit[2] = char_match(STR_MAIL,  LEN_MAIL,  k, byte_in);

        len_hit[0] = (cur_idx == CNT_W'(LEN_NET));
        len_hit[1] = (cur_idx == CNT_W'(LEN_OCTET));
        len_hit[2] = (cur_idx == CNT_W'(LEN_MAIL));

        hits = cur_flags & len_hit & FLAG_INIT;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a terminating byte wins over start, so start+NUL
    // lands directly in DONE
    always_comb begin
        state_nxt = state;
        if (active && en && (is_nul || overflow)) begin
            state_nxt = DONE;
        end else if (start) begin
            state_nxt = MATCH;
        end
    end

    // Next values for index, candidate flags and the held result
    always_comb begin
        idx_nxt   = idx;
        flags_nxt = flags;
        done_nxt  = done;
        valid_nxt = valid;
        error_nxt = error;
        mode_nxt  = mode;

        if (start) begin
            idx_nxt   = '0;
            flags_nxt = FLAG_INIT;
            done_nxt  = 1'b0;
            valid_nxt = 1'b0;
            error_nxt = 1'b0;
            mode_nxt  = 2'd0;
        end

        if (active && en) begin
            if (is_nul) begin
                done_nxt = 1'b1;
                unique case (hits)
                    3'b001: begin
                        valid_nxt = 1'b1;
                        mode_nxt  = 2'd1;
                    end
                    3'b010: begin
                        valid_nxt = 1'b1;
                        mode_nxt  = 2'd2;
                    end
                    3'b100: begin
                        valid_nxt = 1'b1;
                        mode_nxt  = 2'd3;
                    end
                    default: begin
                        error_nxt = 1'b1;
                        mode_nxt  = 2'd0;
                    end
                endcase
            end else if (overflow) begin
                done_nxt  = 1'b1;
                error_nxt = 1'b1;
                mode_nxt  = 2'd0;
            end else begin
                // Mismatches only clear flags; the field is consumed to its end
                flags_nxt = cur_flags & char_hit & FLAG_INIT;
                idx_nxt   = cur_idx + 1'b1;
            end
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx   <= '0;
            flags <= FLAG_INIT;
            done  <= 1'b0;
            valid <= 1'b0;
            error <= 1'b0;
            mode  <= 2'd0;
        end else begin
            idx   <= idx_nxt;
            flags <= flags_nxt;
            done  <= done_nxt;
            valid <= valid_nxt;
            error <= error_nxt;
            mode  <= mode_nxt;
        end
    end

endmodule

// File: doc/tftp_mode_decode.md
Name: tftp_mode_decode

Overview:
Parametrised successor to the single-mode "octet" matcher in the RX path. Consumes the mode field of a TFTP RRQ/WRQ byte-serially after the filename field. Recognises every RFC 1350 mode, optionally case-insensitive, with a bounded field length. Reports a registered mode code plus done/valid/error flags, which hold until the next start pulse.

Parameters:
MAX_LEN, 8, maximum non-NUL mode characters accepted; byte MAX_LEN+1 that is not NUL is an overflow error (must be >= 8)
CASE_INSENSITIVE, 1, 1 folds ASCII 'A'-'Z' to lowercase before compare; 0 requires exact lowercase
CNT_W, 4, width of byte index counter (must hold MAX_LEN+1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  synchronous one-cycle pulse: clear result, begin new mode field
en  input  1  byte strobe; eth_data valid this cycle
eth_data  input  8  mode field byte
done  output  1  field finished (NUL seen or overflow); held
valid  output  1  done with a recognised mode; held
error  output  1  done with no match, empty field or overflow; held
mode  output  2  0 none, 1 netascii, 2 octet, 3 mail; held

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, index=0, all match flags 1; done=valid=error=0, mode=0.
- States: IDLE -> MATCH on start. MATCH -> DONE on NUL or overflow. DONE -> MATCH on start. Start in any state clears done/valid/error/mode/index, sets all match flags and enters MATCH.
- If start and en are high in the same cycle, eth_data is processed as byte index 0 of the new field.
- In IDLE and DONE, en bytes are ignored and outputs are unchanged.
- In MATCH with en=1 and a non-NUL byte:
  - Fold the byte to lowercase when CASE_INSENSITIVE=1.
  - Clear each candidate flag whose string length <= index or whose char[index] != byte.
  - index++.
  - If index was already MAX_LEN, go to DONE with error=1 and mode=0.
- In MATCH with en=1 and byte == 0x00:
  - A candidate is a hit if its flag is still set and its length == index.
  - Exactly one hit: valid=1, mode=code.
  - Zero hits, including index==0: error=1, mode=0.
  - Always done=1 and go to DONE.
- Mismatch does not terminate early. The block keeps consuming until NUL or overflow, so done aligns with the field end.
- Latency: done/valid/error/mode update on the same rising edge that samples the terminating byte, and are visible the following cycle.
- en=0 cycles inside MATCH stall the matcher with no state change.
- Candidate strings: "netascii" (len 8), "octet" (len 5), "mail" (len 4).
- Exactly one of valid/error is set whenever done=1. Both are 0 when done=0.

Optional Feature:
TFTP_MODE_MAIL_EN.
- Defined: "mail" is a candidate and a hit yields mode=3, valid=1.
- Undefined: the mail candidate flag is forced 0. "mail\0" yields error=1, mode=0, and code 3 is never produced.

Test Plan:
- Reset low 1 period, then start+en with 'o','c','t','e','t',0x00 on 6 consecutive edges -> after 6th edge done=1, valid=1, error=0, mode=2.
- start, then "NetAscii\0" with CASE_INSENSITIVE=1 -> valid=1, mode=1.
- Same stimulus with CASE_INSENSITIVE=0 -> error=1, valid=0, mode=0.
- Truncation and overrun: "octe\0" -> error=1. "octets\0" -> error=1, done on the NUL edge.
- Overflow: 9 non-NUL bytes 'x', MAX_LEN=8 -> done=error=1 on the 9th edge; further bytes ignored.
- Empty field 0x00 -> error=1.
- Reset and macro: reset low mid-field after "oct" -> all outputs 0 immediately. Then start + "octet\0" -> valid, mode=2. "mail\0" -> mode=3 with TFTP_MODE_MAIL_EN, error=1 without it.
- Back-to-back restart: after a valid result, start + "netascii\0" clears the old result the cycle after start and ends with mode=1.
